dbg_cmd_responder: RTL



---
 rtl/dbg_cmd_responder_if.sv | 24 ++
 rtl/dbg_cmd_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dbg_cmd_responder_if.sv
// rtl/dbg_cmd_responder_if.sv - core halt handshake and data-memory debug port
// master (responder side): drives cpu_halt, mem_req, mem_we, mem_addr, mem_wdata;
//                          receives cpu_halted, mem_ack, mem_rdata
// slave (core/memory side): the mirror image
interface dbg_cmd_responder_if;
  logic        cpu_halt;
  logic        cpu_halted;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_halt, mem_req, mem_we, mem_addr, mem_wdata,
    input  cpu_halted, mem_ack, mem_rdata
  );

  modport slave (
    input  cpu_halt, mem_req, mem_we, mem_addr, mem_wdata,
    output cpu_halted, mem_ack, mem_rdata
  );
endinterface

// File: rtl/dbg_cmd_responder.sv
// rtl/dbg_cmd_responder.sv - debounced board command -> halt core -> one debug memory access
// clk, reset   : clock, synchronous active-high reset
// addr_in      : word index (bits [29:0] used), latched on acceptance
// data_in      : write data, latched on acceptance
// cmd          : 00 re-arm, 01 read, 10 write, 11 hold the core halted
// bus          : master side of the halt handshake and memory debug port
// data_out     : 16-bit display value (read data, write data, or EEEE on timeout)
// busy         : responder is not idle
// err          : sticky timeout flag, cleared by the next accepted read/write
module dbg_cmd_responder #(
  parameter int STABLE  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                addr_in,
  input  logic [31:0]                data_in,
  input  logic [1:0]                 cmd,
  dbg_cmd_responder_if.master        bus,
  output logic [15:0]                data_out,
  output logic                       busy,
  output logic                       err
);

  localparam int SW = $clog2(STABLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE);
  // Last ACCESS cycle index; the counter starts at 0 on entry, so ACCESS
  // lasts exactly TIMEOUT cycles.
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_ACCESS,
    S_DONE,
    S_HOLD
  } state_t;

  state_t          state;
  logic [1:0]      cmd_q;
  logic [SW-1:0]   stab_cnt;
  logic            cmd_ok;
  logic            armed;
  logic [TW-1:0]   tcnt;

  logic            halt_q;
  logic            req_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;

  logic            unused_bits;
  assign unused_bits = ^{addr_in[31:30], bus.mem_rdata[31:16]};

  assign bus.cpu_halt  = halt_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  // Stability filter: a command level must hold for STABLE cycles after it
  // was first seen before cmd_ok rises. Runs in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= 2'b00;
      stab_cnt <= '0;
    end else if (cmd != cmd_q) begin
      cmd_q    <= cmd;
      stab_cnt <= '0;
    end else if (!cmd_ok) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  assign cmd_ok = (stab_cnt == STAB_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      tcnt     <= '0;
      halt_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_out <= 16'h0000;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // A stable 00 re-arms from any state, so a command changed mid
      // transaction only takes effect after the current one finishes.
      if (cmd_ok && cmd_q == 2'b00) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (cmd_ok && armed && (cmd_q == 2'b01 || cmd_q == 2'b10)) begin
            armed   <= 1'b0;
            addr_q  <= {addr_in[29:0], 2'b00};
            wdata_q <= data_in;
            we_q    <= cmd_q[1];
            err     <= 1'b0;
            halt_q  <= 1'b1;
            busy    <= 1'b1;
            state   <= S_HALT_WAIT;
          end else if (cmd_ok && cmd_q == 2'b11) begin
            halt_q  <= 1'b1;
            busy    <= 1'b1;
            state   <= S_HOLD;
          end
        end

        S_HALT_WAIT: begin
          if (bus.cpu_halted) begin
            req_q <= 1'b1;
            tcnt  <= '0;
            state <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          // An ack in the final counted cycle still beats the timeout.
          if (bus.mem_ack) begin
            req_q    <= 1'b0;
            data_out <= we_q ? wdata_q[15:0] : bus.mem_rdata[15:0];
            state    <= S_DONE;
          end else if (tcnt == TO_LAST) begin
            req_q    <= 1'b0;
            data_out <= 16'hEEEE;
            err      <= 1'b1;
            state    <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        S_DONE: begin
          // First DONE cycle drops the halt request, second returns to idle,
          // giving the core one cycle to resume before a new command can start.
          if (halt_q) begin
            halt_q <= 1'b0;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_HOLD: begin
          if (cmd_ok && cmd_q != 2'b11) begin
            halt_q <= 1'b0;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end

        default: begin
          halt_q <= 1'b0;
          req_q  <= 1'b0;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
